// File: rtl/error_frame_generator_pkg.sv
// Shared CAN definitions for error-frame generation: state encoding, default
// flag/delimiter lengths and the dominant-sequence length.
package error_frame_generator_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLAG     = 2'd1,
    WAIT_REC = 2'd2,
    DELIM    = 2'd3
  } efg_state_e;

  localparam int FLAG_LEN_DEF  = 6;
  localparam int DELIM_LEN_DEF = 8;
  // Must stay a power of two: the dominant counter relies on natural wrap.
  localparam int DOM_SEQ_LEN   = 8;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/error_frame_generator_bit_counter.sv
// SP-enabled up-counter with clear and a terminal-count compare on the value
// the counter would take after the next increment.
module bit_counter #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic [W:0]   term_i,
  output logic         hit_o
);
  logic [W-1:0] cnt_q, cnt_d;
  logic [W:0]   nxt;

  always_comb begin
    nxt   = {1'b0, cnt_q} + {{W{1'b0}}, 1'b1};
    hit_o = (nxt == term_i);
    cnt_d = cnt_q;
    if (en_i) begin
      // clear+inc together loads 1
      cnt_d = clr_i ? '0 : cnt_q;
      if (inc_i) cnt_d = cnt_d + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/error_frame_generator.sv
// CAN error-frame generator: drives the error flag, waits for the bus to go
// recessive, then counts the delimiter; restarts on a dominant delimiter bit.
module error_frame_generator
  import error_frame_generator_pkg::*;
#(
  parameter int FLAG_LEN  = FLAG_LEN_DEF,
  parameter int DELIM_LEN = DELIM_LEN_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic SP,
  input  logic RX,
  input  logic ERROR,
  input  logic PASSIVE,
  output logic TX,
  output logic ERR_FRAME,
  output logic BIT_ERR,
  output logic DOM_SEQ,
  output logic DONE
);
  localparam int CW = cnt_width((FLAG_LEN > DELIM_LEN) ? FLAG_LEN : DELIM_LEN);
  localparam int DW = cnt_width(DOM_SEQ_LEN - 1);

  efg_state_e state_q, state_d;
  logic       mode_q, mode_d;   // 1 = passive
  logic       tx_q, tx_d, ef_q, ef_d;
  logic       be_q, be_d, ds_q, ds_d, dn_q, dn_d;
  logic       bc_clr, bc_inc, bc_hit, dc_clr, dc_inc, dc_hit;
  logic [CW:0] bc_term;

  bit_counter #(.W(CW)) u_bit_cnt (
    .clk_i(clock), .rst_ni(reset), .en_i(SP), .clr_i(bc_clr), .inc_i(bc_inc),
    .term_i(bc_term), .hit_o(bc_hit)
  );

  bit_counter #(.W(DW)) u_dom_cnt (
    .clk_i(clock), .rst_ni(reset), .en_i(SP), .clr_i(dc_clr), .inc_i(dc_inc),
    .term_i((DW+1)'(DOM_SEQ_LEN)), .hit_o(dc_hit)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    bc_clr  = 1'b0;
    bc_inc  = 1'b0;
    dc_clr  = 1'b0;
    dc_inc  = 1'b0;
    be_d    = 1'b0;
    ds_d    = 1'b0;
    dn_d    = 1'b0;
    bc_term = (state_q == FLAG) ? (CW+1)'(FLAG_LEN) : (CW+1)'(DELIM_LEN);
    if (SP) begin
      unique case (state_q)
        IDLE: if (ERROR) begin
          state_d = FLAG;
          bc_clr  = 1'b1;
          mode_d  = PASSIVE;
        end
        FLAG: begin
          bc_inc = 1'b1;
          dc_clr = 1'b1;
          if (!mode_q && RX) be_d = 1'b1;
          if (bc_hit) begin
            state_d = WAIT_REC;
            bc_clr  = 1'b1;
            bc_inc  = 1'b0;
          end
        end
        WAIT_REC: if (RX) begin
          state_d = DELIM;
          bc_clr  = 1'b1;
          bc_inc  = 1'b1;
          dc_clr  = 1'b1;
        end else begin
          dc_inc = 1'b1;
          ds_d   = dc_hit;
        end
        DELIM: if (RX) begin
          bc_inc = 1'b1;
          if (bc_hit) begin
            state_d = IDLE;
            bc_clr  = 1'b1;
            bc_inc  = 1'b0;
            dn_d    = 1'b1;
          end
        end else begin
          state_d = FLAG;
          bc_clr  = 1'b1;
          mode_d  = PASSIVE;
        end
        default: state_d = IDLE;
      endcase
    end
    tx_d = !((state_d == FLAG) && !mode_d);
    ef_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      tx_q    <= 1'b1;
      ef_q    <= 1'b0;
      be_q    <= 1'b0;
      ds_q    <= 1'b0;
      dn_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      tx_q    <= tx_d;
      ef_q    <= ef_d;
      be_q    <= be_d;
      ds_q    <= ds_d;
      dn_q    <= dn_d;
    end
  end

  assign TX        = tx_q;
  assign ERR_FRAME = ef_q;
  assign BIT_ERR   = be_q;
  assign DOM_SEQ   = ds_q;
  assign DONE      = dn_q;

endmodule

// File: tb/tb_error_frame_generator.sv
// Bench for error_frame_generator: vector table, directed corner sequences and
// random bits checked against a bit-level reference model.
module tb_error_frame_generator;
  localparam int FL = 6;
  localparam int DL = 8;

  logic clock = 1'b0, reset = 1'b1, SP = 1'b0, RX = 1'b1, ERROR = 1'b0, PASSIVE = 1'b0;
  logic TX, ERR_FRAME, BIT_ERR, DOM_SEQ, DONE;
  int   checks = 0, errors = 0;

  error_frame_generator #(.FLAG_LEN(FL), .DELIM_LEN(DL)) dut (
    .clock(clock), .reset(reset), .SP(SP), .RX(RX), .ERROR(ERROR), .PASSIVE(PASSIVE),
    .TX(TX), .ERR_FRAME(ERR_FRAME), .BIT_ERR(BIT_ERR), .DOM_SEQ(DOM_SEQ), .DONE(DONE)
  );

  always #5 clock = ~clock;

  // reference model: phase 0 idle, 1 flag, 2 waiting for recessive, 3 delimiter
  int m_phase, m_bits, m_dom;
  bit m_pass;
  bit e_tx, e_ef, e_be, e_ds, e_dn;
  logic s_tx, s_ef, s_be, s_ds, s_dn;
  int n_be, n_ds, n_dn, n_tx0;

  typedef struct {
    bit rx, err, pas;
    bit tx, ef, be, ds, dn;
  } vec_t;
  vec_t tbl[15];

  function automatic void model_reset();
    m_phase = 0; m_bits = 0; m_dom = 0; m_pass = 1'b0;
    e_tx = 1'b1; e_ef = 1'b0;
  endfunction

  function automatic void model_sp(input bit rx, input bit err, input bit pas);
    e_be = 1'b0; e_ds = 1'b0; e_dn = 1'b0;
    case (m_phase)
      0: if (err) begin m_phase = 1; m_bits = 0; m_pass = pas; end
      1: begin
        m_bits++;
        if (!m_pass && rx) e_be = 1'b1;
        if (m_bits == FL) begin m_phase = 2; m_dom = 0; end
      end
      2: if (rx) begin m_phase = 3; m_bits = 1; end
         else begin m_dom++; e_ds = (m_dom % 8 == 0); end
      default: if (rx) begin
        m_bits++;
        if (m_bits == DL) begin m_phase = 0; e_dn = 1'b1; end
      end else begin
        m_phase = 1; m_bits = 0; m_pass = pas;
      end
    endcase
    e_tx = !(m_phase == 1 && !m_pass);
    e_ef = (m_phase != 0);
  endfunction

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0b required=%0b t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_n(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // one CAN bit: an SP clock, then a non-SP clock with junk inputs that must be ignored
  task automatic do_bit(input logic rx, input logic err, input logic pas);
    @(negedge clock);
    SP = 1'b1; RX = rx; ERROR = err; PASSIVE = pas;
    @(posedge clock); #1;
    model_sp(rx, err, pas);
    s_tx = TX; s_ef = ERR_FRAME; s_be = BIT_ERR; s_ds = DOM_SEQ; s_dn = DONE;
    n_be += int'(BIT_ERR); n_ds += int'(DOM_SEQ); n_dn += int'(DONE);
    n_tx0 += int'(!TX);
    chk("tx", TX, e_tx);
    chk("err_frame", ERR_FRAME, e_ef);
    chk("bit_err", BIT_ERR, e_be);
    chk("dom_seq", DOM_SEQ, e_ds);
    chk("done", DONE, e_dn);
    @(negedge clock);
    SP = 1'b0; RX = 1'($urandom); ERROR = 1'($urandom); PASSIVE = 1'($urandom);
    @(posedge clock); #1;
    chk("hold_tx", TX, e_tx);
    chk("hold_err_frame", ERR_FRAME, e_ef);
    chk("hold_pulses", BIT_ERR | DOM_SEQ | DONE, 1'b0);
  endtask

  task automatic clr_counts();
    n_be = 0; n_ds = 0; n_dn = 0; n_tx0 = 0;
  endtask

  initial begin
    clr_counts();
    tbl[0] = '{1, 1, 0,  0, 1, 0, 0, 0};
    for (int i = 1; i <= 5; i++) tbl[i] = '{0, 0, 0,  0, 1, 0, 0, 0};
    tbl[6] = '{0, 0, 0,  1, 1, 0, 0, 0};
    for (int i = 7; i <= 13; i++) tbl[i] = '{1, 0, 0,  1, 1, 0, 0, 0};
    tbl[14] = '{1, 0, 0,  1, 0, 0, 0, 1};

    #2 reset = 1'b0;
    #1;
    chk("rst_tx", TX, 1'b1);
    chk("rst_err_frame", ERR_FRAME, 1'b0);
    chk("rst_pulses", BIT_ERR | DOM_SEQ | DONE, 1'b0);
    model_reset();
    @(negedge clock); reset = 1'b1;

    // active frame, RX mirrors TX
    for (int i = 0; i < 15; i++) begin
      do_bit(tbl[i].rx, tbl[i].err, tbl[i].pas);
      chk("tbl_tx", s_tx, tbl[i].tx);
      chk("tbl_ef", s_ef, tbl[i].ef);
      chk("tbl_be", s_be, tbl[i].be);
      chk("tbl_ds", s_ds, tbl[i].ds);
      chk("tbl_dn", s_dn, tbl[i].dn);
    end

    // passive frame: TX never dominant
    clr_counts();
    do_bit(1, 1, 1);
    for (int i = 0; i < FL + DL; i++) do_bit(1, 0, 0);
    chk_n("passive_tx_dominant", n_tx0, 0);
    chk_n("passive_done_count", n_dn, 1);
    chk("passive_ef_end", s_ef, 1'b0);

    // bit error at third flag bit
    clr_counts();
    do_bit(1, 1, 0);
    for (int i = 1; i <= FL; i++) begin
      do_bit(i == 3, 0, 0);
      if (i == 5) chk("biterr_flag_bit5_tx", s_tx, 1'b0);
    end
    chk("biterr_flag_end_tx", s_tx, 1'b1);
    chk_n("biterr_count", n_be, 1);
    for (int i = 0; i < DL; i++) do_bit(1, 0, 0);
    chk_n("biterr_done", n_dn, 1);

    // 16 dominant bits while waiting for recessive
    clr_counts();
    do_bit(1, 1, 0);
    for (int i = 0; i < FL; i++) do_bit(0, 0, 0);
    for (int i = 1; i <= 16; i++) begin
      do_bit(0, 0, 0);
      if (i == 8 || i == 16) chk("domseq_at_8th", s_ds, 1'b1);
    end
    chk_n("domseq_count", n_ds, 2);
    for (int i = 0; i < DL; i++) do_bit(1, 0, 0);
    chk_n("domseq_done", n_dn, 1);

    // dominant delimiter bit 4 restarts the flag
    clr_counts();
    do_bit(1, 1, 0);
    for (int i = 0; i < FL; i++) do_bit(0, 0, 0);
    for (int i = 0; i < 3; i++) do_bit(1, 0, 0);
    do_bit(0, 0, 0);
    chk("restart_tx", s_tx, 1'b0);
    n_tx0 = 0;
    for (int i = 0; i < FL; i++) do_bit(0, 0, 0);
    chk_n("restart_flag_len", n_tx0, FL - 1);
    chk_n("restart_no_early_done", n_dn, 0);
    for (int i = 0; i < DL; i++) do_bit(1, 0, 0);
    chk_n("restart_done", n_dn, 1);

    // async reset during flag bit 3
    do_bit(1, 1, 0);
    for (int i = 0; i < 3; i++) do_bit(0, 0, 0);
    @(negedge clock); #1 reset = 1'b0;
    #1;
    chk("midrst_tx", TX, 1'b1);
    chk("midrst_err_frame", ERR_FRAME, 1'b0);
    model_reset();
    @(negedge clock); reset = 1'b1;
    clr_counts();
    do_bit(1, 1, 0);
    chk("midrst_restart_tx", s_tx, 1'b0);
    for (int i = 0; i < FL; i++) do_bit(0, 0, 0);
    for (int i = 0; i < DL; i++) do_bit(1, 0, 0);
    chk_n("midrst_done", n_dn, 1);

    // random bits against the model
    repeat (600) do_bit($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, 1'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
